tilt_sequencer: RTL and testbench

Sequences the shared CORDIC vectoring engine to turn one raw accelerometer sample (ax, ay, az) into roll and pitch angles. Sits directly upstream of the CORDIC block and drives its x/y/start inputs. It also consumes the CORDIC done/angle/magnitude outputs and issues two chained requests per sample. Produces a one-cycle-valid tilt result for the attitude filter.

---
 rtl/tilt_sequencer.sv | 159 +++++++++++++++
 tb/tb_tilt_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tilt_sequencer.sv
// -----------------------------------------------------------------------------
// tilt_sequencer
//
// Purpose:
//   Drives the shared CORDIC vectoring engine to turn one raw accelerometer
//   sample (ax, ay, az) into roll and pitch angles. Each accepted sample
//   issues two chained CORDIC requests:
//     1) vector (az, ay)             -> roll  = angle, keep magnitude
//     2) vector (magnitude, -ax)     -> pitch = angle
//   The finished pair is presented with a one-cycle tilt_valid pulse.
//
// Parameters:
//   TIMEOUT        max cycles to wait for crd_done per request (>= 16)
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   ax, ay, az     signed 16-bit accelerometer sample
//   acc_valid      one-cycle strobe, sample valid this cycle
//   crd_x, crd_y   signed 24-bit CORDIC input vector (held between requests)
//   crd_start      one-cycle CORDIC request pulse
//   crd_done       one-cycle CORDIC completion pulse
//   crd_angle      CORDIC angle result, 16384 = 90 degrees
//   crd_magnitude  gain-compensated CORDIC magnitude result
//   roll, pitch    tilt angles, 16384 = 90 degrees
//   tilt_valid     one-cycle pulse, roll/pitch just updated
//   busy           high from sample accept until return to IDLE
//   overrun        one-cycle pulse, an incoming sample was dropped
//   timeout_err    sticky abort flag, cleared by the next accepted sample
// -----------------------------------------------------------------------------
module tilt_sequencer #(
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] ax,
    input  logic signed [15:0] ay,
    input  logic signed [15:0] az,
    input  logic               acc_valid,
    output logic signed [23:0] crd_x,
    output logic signed [23:0] crd_y,
    output logic               crd_start,
    input  logic               crd_done,
    input  logic signed [23:0] crd_angle,
    input  logic signed [23:0] crd_magnitude,
    output logic signed [23:0] roll,
    output logic signed [23:0] pitch,
    output logic               tilt_valid,
    output logic               busy,
    output logic               overrun,
    output logic               timeout_err
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] ROLL_WAIT  = 2'd1;
    localparam logic [1:0] PITCH_WAIT = 2'd2;

    localparam int             CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]         r_state;
    logic [CW-1:0]      r_count;
    logic signed [15:0] r_axLatched;

    logic signed [23:0] w_azExt;
    logic signed [23:0] w_ayExt;
    logic signed [23:0] w_negAx;
    logic               w_doneValid;

    // Sign extension of the 16-bit sample into the 24-bit CORDIC datapath.
    // The negation is done after widening so -(-32768) becomes +32768.
    assign w_azExt = {{8{az[15]}}, az};
    assign w_ayExt = {{8{ay[15]}}, ay};
    assign w_negAx = -{{8{r_axLatched[15]}}, r_axLatched};

    // A done pulse arriving while our own request is still being presented
    // belongs to an earlier (stale) request and must not be taken as ours.
    assign w_doneValid = crd_done && !crd_start;

    // Main sequencer: accepts a sample in IDLE, issues the roll request,
    // chains the pitch request off the roll magnitude, and publishes both
    // angles. Each wait state has its own timeout; a missing done aborts the
    // sample back to IDLE with the sticky error flag raised. Samples that
    // arrive while not in IDLE (including the edge that returns to IDLE) are
    // dropped and flagged with overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_axLatched <= '0;
            crd_x       <= '0;
            crd_y       <= '0;
            crd_start   <= 1'b0;
            roll        <= '0;
            pitch       <= '0;
            tilt_valid  <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            crd_start  <= 1'b0;
            tilt_valid <= 1'b0;
            overrun    <= acc_valid && (r_state != IDLE);

            case (r_state)
                IDLE: begin
                    if (acc_valid) begin
                        r_axLatched <= ax;
                        crd_x       <= w_azExt;
                        crd_y       <= w_ayExt;
                        crd_start   <= 1'b1;
                        busy        <= 1'b1;
                        timeout_err <= 1'b0;
                        r_count     <= '0;
                        r_state     <= ROLL_WAIT;
                    end
                end

                ROLL_WAIT: begin
                    if (w_doneValid) begin
                        roll      <= crd_angle;
                        crd_x     <= crd_magnitude;
                        crd_y     <= w_negAx;
                        crd_start <= 1'b1;
                        r_count   <= '0;
                        r_state   <= PITCH_WAIT;
                    end else if (r_count == CNT_LAST) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        r_state     <= IDLE;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end

                PITCH_WAIT: begin
                    if (w_doneValid) begin
                        pitch      <= crd_angle;
                        tilt_valid <= 1'b1;
                        busy       <= 1'b0;
                        r_state    <= IDLE;
                    end else if (r_count == CNT_LAST) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        r_state     <= IDLE;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end

                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tilt_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tilt_sequencer
//
// Purpose:
//   Self-checking bench for tilt_sequencer. The bench plays the CORDIC engine
//   itself: it answers each request after a chosen latency with angle and
//   magnitude computed from real-number atan2/sqrt of the vector it expects
//   the sequencer to send, and predicts roll/pitch from the raw sample.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_tilt_sequencer;

    localparam int TIMEOUT = 64;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] ax;
    logic signed [15:0] ay;
    logic signed [15:0] az;
    logic               accValid;
    logic               crdDone;
    logic signed [23:0] crdAngle;
    logic signed [23:0] crdMagnitude;
    logic signed [23:0] crdX;
    logic signed [23:0] crdY;
    logic               crdStart;
    logic signed [23:0] roll;
    logic signed [23:0] pitch;
    logic               tiltValid;
    logic               busy;
    logic               overrun;
    logic               timeoutErr;

    int checks   = 0;
    int failures = 0;

    longint expRoll  = 0;
    longint expPitch = 0;

    tilt_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .ax            (ax),
        .ay            (ay),
        .az            (az),
        .acc_valid     (accValid),
        .crd_x         (crdX),
        .crd_y         (crdY),
        .crd_start     (crdStart),
        .crd_done      (crdDone),
        .crd_angle     (crdAngle),
        .crd_magnitude (crdMagnitude),
        .roll          (roll),
        .pitch         (pitch),
        .tilt_valid    (tiltValid),
        .busy          (busy),
        .overrun       (overrun),
        .timeout_err   (timeoutErr)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Ideal CORDIC angle: atan2 scaled so that 16384 = 90 degrees.
    function automatic longint cordicAngle(input longint x, input longint y);
        real a;
        a = $atan2(real'(y), real'(x)) * 32768.0 / 3.141592653589793;
        return longint'($rtoi(a < 0.0 ? a - 0.5 : a + 0.5));
    endfunction

    // Ideal gain-compensated CORDIC magnitude.
    function automatic longint cordicMag(input longint x, input longint y);
        return longint'($rtoi($sqrt(real'(x * x + y * y)) + 0.5));
    endfunction

    // One comparison: counts it, and on mismatch counts a failure and reports.
    task automatic checkOutput(input string tag, input logic [23:0] obs,
                               input longint expected);
        logic [23:0] e;
        e = 24'(expected);
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag,
                   $signed(obs), $signed(e));
        end
    endtask

    // Advance one clock; inputs and samples are handled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one sample for a single cycle; returns just after accept edge E0.
    task automatic applyStimulus(input longint sx, input longint sy,
                                 input longint sz);
        ax       = 16'(sx);
        ay       = 16'(sy);
        az       = 16'(sz);
        accValid = 1'b1;
        step();
        accValid = 1'b0;
    endtask

    // Full sample: roll request answered lat1 edges after E0, pitch request
    // lat2 edges after the roll capture. Optional overrun at E5 / on the
    // tilt_valid edge, and an optional stale done during the start cycle.
    task automatic runSequence(input longint sx, input longint sy,
                               input longint sz, input int lat1,
                               input int lat2, input bit ovrMid,
                               input bit ovrEnd, input bit staleDone);
        longint r, m, nx, p;
        r  = cordicAngle(sz, sy);
        m  = cordicMag(sz, sy);
        nx = -sx;
        p  = cordicAngle(m, nx);

        applyStimulus(sx, sy, sz);
        checkOutput("req1_start", crdStart, 1);
        checkOutput("req1_busy", busy, 1);
        checkOutput("req1_x", crdX, sz);
        checkOutput("req1_y", crdY, sy);
        checkOutput("req1_err_clr", timeoutErr, 0);

        if (staleDone) begin
            crdDone  = 1'b1;
            crdAngle = 24'sd4321;
        end
        for (int i = 1; i <= lat1; i++) begin
            step();
            crdDone = 1'b0;
            if (i == 1) checkOutput("req1_pulse", crdStart, 0);
            if (ovrMid && i == 4) accValid = 1'b1;
            if (ovrMid && i == 5) begin
                checkOutput("ovr_mid", overrun, 1);
                accValid = 1'b0;
            end
            if (ovrMid && i == 6) checkOutput("ovr_mid_end", overrun, 0);
        end
        crdDone      = 1'b1;
        crdAngle     = 24'(r);
        crdMagnitude = 24'(m);
        step();
        crdDone = 1'b0;
        checkOutput("roll", roll, r);
        checkOutput("req2_start", crdStart, 1);
        checkOutput("req2_x", crdX, m);
        checkOutput("req2_y", crdY, nx);
        checkOutput("req2_busy", busy, 1);

        for (int i = 1; i <= lat2; i++) begin
            step();
            if (i == 1) checkOutput("req2_pulse", crdStart, 0);
            if (i == lat2) checkOutput("no_early_valid", tiltValid, 0);
        end
        crdDone      = 1'b1;
        crdAngle     = 24'(p);
        crdMagnitude = 24'sd0;
        accValid     = ovrEnd;
        step();
        crdDone  = 1'b0;
        accValid = 1'b0;
        checkOutput("tilt_valid", tiltValid, 1);
        checkOutput("pitch", pitch, p);
        checkOutput("roll_hold", roll, r);
        checkOutput("busy_done", busy, 0);
        checkOutput("ovr_end", overrun, longint'(ovrEnd));
        step();
        checkOutput("tilt_pulse", tiltValid, 0);
        checkOutput("no_accept", crdStart, 0);
        checkOutput("idle_busy", busy, 0);
        expRoll  = r;
        expPitch = p;
    endtask

    // Sample whose roll request is never answered.
    task automatic runTimeout(input longint sx, input longint sy,
                              input longint sz);
        applyStimulus(sx, sy, sz);
        for (int i = 1; i < TIMEOUT; i++) step();
        checkOutput("to_busy_before", busy, 1);
        checkOutput("to_err_before", timeoutErr, 0);
        step();
        checkOutput("to_err", timeoutErr, 1);
        checkOutput("to_busy", busy, 0);
        checkOutput("to_no_valid", tiltValid, 0);
        checkOutput("to_roll", roll, expRoll);
        checkOutput("to_pitch", pitch, expPitch);
        step();
        checkOutput("to_sticky", timeoutErr, 1);
    endtask

    // Reset asserted ten edges into a sequence, then a late done in IDLE.
    task automatic runReset();
        applyStimulus(0, 16384, 16384);
        for (int i = 1; i <= 10; i++) step();
        rst = 1'b1;
        #1;
        checkOutput("rst_x", crdX, 0);
        checkOutput("rst_y", crdY, 0);
        checkOutput("rst_start", crdStart, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_roll", roll, 0);
        step();
        rst = 1'b0;
        step();
        crdDone  = 1'b1;
        crdAngle = 24'sd999;
        step();
        crdDone = 1'b0;
        step();
        checkOutput("late_valid", tiltValid, 0);
        checkOutput("late_roll", roll, 0);
        checkOutput("late_busy", busy, 0);
        expRoll  = 0;
        expPitch = 0;
    endtask

    initial begin
        rst          = 1'b1;
        ax           = '0;
        ay           = '0;
        az           = '0;
        accValid     = 1'b0;
        crdDone      = 1'b0;
        crdAngle     = '0;
        crdMagnitude = '0;
        step();
        step();
        checkOutput("reset_x", crdX, 0);
        checkOutput("reset_y", crdY, 0);
        checkOutput("reset_roll", roll, 0);
        checkOutput("reset_pitch", pitch, 0);
        checkOutput("reset_start", crdStart, 0);
        checkOutput("reset_valid", tiltValid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_overrun", overrun, 0);
        checkOutput("reset_err", timeoutErr, 0);
        rst = 1'b0;
        step();

        $display("[TB] directed samples");
        runSequence(0, 0, 16384, 15, 15, 1'b0, 1'b0, 1'b0);
        runSequence(0, 16384, 16384, 15, 15, 1'b0, 1'b0, 1'b0);
        runSequence(-16384, 0, 16384, 15, 15, 1'b0, 1'b0, 1'b0);
        runSequence(-32768, 0, 1, 15, 15, 1'b0, 1'b0, 1'b0);
        runSequence(1000, 0, 0, 2, 15, 1'b0, 1'b0, 1'b0);

        $display("[TB] overrun and stale done");
        runSequence(1234, -5678, 20000, 15, 15, 1'b1, 1'b1, 1'b0);
        runSequence(-300, 700, -9000, 12, 9, 1'b0, 1'b0, 1'b1);

        $display("[TB] timeout");
        runTimeout(100, 200, 300);
        runSequence(500, -600, 15000, 15, 15, 1'b0, 1'b0, 1'b0);

        $display("[TB] reset mid-sequence");
        runReset();
        runSequence(-2000, 3000, 12000, 15, 15, 1'b0, 1'b0, 1'b0);

        $display("[TB] randomized samples");
        for (int n = 0; n < 12; n++) begin
            longint rx, ry, rz;
            bit     om;
            rx = longint'($signed(16'($urandom)));
            ry = longint'($signed(16'($urandom)));
            rz = longint'($signed(16'($urandom)));
            om = 1'($urandom);
            runSequence(rx, ry, rz, int'($urandom_range(6, 20)),
                        int'($urandom_range(2, 20)), om,
                        1'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
